// File: rtl/lane_sync_ctrl.sv
// lane_sync_ctrl: COM-based lane alignment with bit-slip hunting, sync loss detection
// and payload forwarding with COM/IDLE stripping.
module lane_sync_ctrl #(
    parameter logic [7:0] COM         = 8'hBC,
    parameter logic [7:0] IDLE        = 8'h7C,
    parameter int         LOCK_CNT    = 4,
    parameter int         SLIP_WINDOW = 16,
    parameter int         SLIP_HOLD   = 2,
    parameter int         LOSS_CNT    = 3
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic       bit_slip,
    output logic       sync_active,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic [7:0] err_cnt
);
    typedef enum logic [1:0] {SEARCH, LOCKING, SLIP_WAIT, ACTIVE} state_t;
    state_t     state;
    logic [7:0] window;
    logic [3:0] com_cnt;
    logic [3:0] hold;
    logic [3:0] idle_run;
    logic [7:0] err_inc;
    always_comb err_inc = err_cnt + {7'd0, err_cnt != 8'hFF};
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state       <= SEARCH;
            window      <= '0;
            com_cnt     <= '0;
            hold        <= '0;
            idle_run    <= '0;
            bit_slip    <= 1'b0;
            sync_active <= 1'b0;
            data_out    <= '0;
            valid_out   <= 1'b0;
            err_cnt     <= '0;
        end else begin
            bit_slip  <= 1'b0;
            valid_out <= 1'b0;
            case (state)
                SEARCH: if (rx_valid) begin
                    if (rx_byte == COM) begin
                        window <= '0;
                        if (LOCK_CNT == 1) begin
                            state       <= ACTIVE;
                            sync_active <= 1'b1;
                            com_cnt     <= '0;
                        end else begin
                            state   <= LOCKING;
                            com_cnt <= 4'd1;
                        end
                    end else if (window == 8'(SLIP_WINDOW - 1)) begin
                        bit_slip <= 1'b1;
                        err_cnt  <= err_inc;
                        state    <= SLIP_WAIT;
                        window   <= '0;
                        hold     <= '0;
                    end else begin
                        window <= window + 8'd1;
                    end
                end
                // The slip cycle itself plus SLIP_HOLD more cycles are ignored.
                SLIP_WAIT: if (hold == 4'(SLIP_HOLD)) begin
                    state  <= SEARCH;
                    hold   <= '0;
                    window <= '0;
                end else begin
                    hold <= hold + 4'd1;
                end
                LOCKING: if (rx_valid) begin
                    if (rx_byte == COM && com_cnt == 4'(LOCK_CNT - 1)) begin
                        state       <= ACTIVE;
                        sync_active <= 1'b1;
                        com_cnt     <= '0;
                    end else if (rx_byte == COM) begin
                        com_cnt <= com_cnt + 4'd1;
                    end else begin
                        state   <= SEARCH;
                        com_cnt <= '0;
                        window  <= '0;
                    end
                end
                ACTIVE: if (rx_valid) begin
                    idle_run <= '0;
                    if (rx_byte != COM && rx_byte != IDLE) begin
                        data_out  <= rx_byte;
                        valid_out <= 1'b1;
                    end
                end else if (idle_run == 4'(LOSS_CNT - 1)) begin
                    state       <= SEARCH;
                    sync_active <= 1'b0;
                    err_cnt     <= err_inc;
                    idle_run    <= '0;
                    window      <= '0;
                    com_cnt     <= '0;
                end else begin
                    idle_run <= idle_run + 4'd1;
                end
                default: state <= SEARCH;
            endcase
        end
    end
endmodule

// File: tb/tb_lane_sync_ctrl.sv
// tb_lane_sync_ctrl: directed plus randomized checks of lane_sync_ctrl against a
// per-byte behavioural model of hunting, locking, slipping and forwarding.
module tb_lane_sync_ctrl;
    localparam int LOCK = 4, WIN = 16, HOLD = 2, LOSS = 3;
    localparam logic [7:0] K_COM = 8'hBC, K_IDLE = 8'h7C;
    logic       clk_4f = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_valid = 1'b0;
    logic       bit_slip, sync_active, valid_out;
    logic [7:0] data_out, err_cnt;
    int checks = 0, errors = 0;
    int m_mode, m_coms, m_noncom, m_ign, m_dead, m_err;
    logic m_slip, m_sync, m_vout;
    logic [7:0] m_dout;

    lane_sync_ctrl dut (
        .clk_4f(clk_4f), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .bit_slip(bit_slip), .sync_active(sync_active), .data_out(data_out),
        .valid_out(valid_out), .err_cnt(err_cnt)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Mode 0 hunts (consecutive COMs / non-COM run), 1 ignores input, 2 is locked.
    task automatic model(input logic r, input logic v, input logic [7:0] b);
        m_slip = 1'b0;
        m_vout = 1'b0;
        if (r) begin
            m_mode = 0; m_coms = 0; m_noncom = 0; m_ign = 0; m_dead = 0;
            m_err = 0; m_sync = 1'b0; m_dout = 8'h00;
        end else if (m_mode == 1) begin
            m_ign = m_ign - 1;
            if (m_ign == 0) m_mode = 0;
        end else if (m_mode == 2) begin
            if (v) begin
                m_dead = 0;
                if (b != K_COM && b != K_IDLE) begin
                    m_dout = b;
                    m_vout = 1'b1;
                end
            end else begin
                m_dead = m_dead + 1;
                if (m_dead == LOSS) begin
                    m_mode = 0; m_sync = 1'b0; m_dead = 0; m_coms = 0; m_noncom = 0;
                    if (m_err < 255) m_err = m_err + 1;
                end
            end
        end else if (v) begin
            if (b == K_COM) begin
                m_coms = m_coms + 1;
                m_noncom = 0;
                if (m_coms == LOCK) begin
                    m_mode = 2; m_sync = 1'b1; m_coms = 0;
                end
            end else if (m_coms > 0) begin
                m_coms = 0;
                m_noncom = 0;
            end else begin
                m_noncom = m_noncom + 1;
                if (m_noncom == WIN) begin
                    m_slip = 1'b1; m_mode = 1; m_ign = HOLD + 1; m_noncom = 0;
                    if (m_err < 255) m_err = m_err + 1;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] b);
        reset = r;
        rx_valid = v;
        rx_byte = b;
        @(posedge clk_4f);
        model(r, v, b);
        #1;
        chk("bit_slip", {7'd0, bit_slip}, {7'd0, m_slip});
        chk("sync_active", {7'd0, sync_active}, {7'd0, m_sync});
        chk("valid_out", {7'd0, valid_out}, {7'd0, m_vout});
        chk("data_out", data_out, m_dout);
        chk("err_cnt", err_cnt, 8'(m_err));
    endtask

    task automatic reset_outputs(input string tag);
        chk({tag, "_slip"}, {7'd0, bit_slip}, 8'd0);
        chk({tag, "_sync"}, {7'd0, sync_active}, 8'd0);
        chk({tag, "_vout"}, {7'd0, valid_out}, 8'd0);
        chk({tag, "_dout"}, data_out, 8'd0);
        chk({tag, "_err"}, err_cnt, 8'd0);
    endtask

    initial begin
        logic [7:0] seq [7];
        logic [7:0] pay [4];
        seq = '{8'hBC, 8'hBC, 8'h12, 8'hBC, 8'hBC, 8'hBC, 8'hBC};
        pay = '{8'hA1, 8'h7C, 8'hBC, 8'hB2};
        step(1, 0, 8'h00);
        step(1, 0, 8'h00);
        reset_outputs("reset");
        // Continuous COMs lock after the 4th.
        for (int i = 1; i <= 6; i++) begin
            step(0, 1, K_COM);
            chk("lock_sync", {7'd0, sync_active}, {7'd0, i >= LOCK});
            chk("lock_vout", {7'd0, valid_out}, 8'd0);
        end
        chk("lock_err", err_cnt, 8'd0);
        // Window expiry with no COM.
        step(1, 0, 8'h00);
        for (int i = 1; i <= WIN; i++) step(0, 1, 8'h55);
        chk("slip_pulse", {7'd0, bit_slip}, 8'd1);
        chk("slip_err", err_cnt, 8'd1);
        for (int i = 0; i < HOLD + 1; i++) begin
            step(0, 1, K_COM);
            chk("slip_hold", {7'd0, bit_slip}, 8'd0);
        end
        for (int i = 1; i <= WIN; i++) step(0, i[0], 8'h55);
        for (int i = 1; i <= 12; i++) step(0, 1, 8'h55);
        chk("slip_again_err", err_cnt, 8'd2);
        // Aborted lock, then clean lock.
        step(1, 0, 8'h00);
        foreach (seq[i]) step(0, 1, seq[i]);
        chk("abort_sync", {7'd0, sync_active}, 8'd1);
        chk("abort_err", err_cnt, 8'd0);
        // Payload stripping.
        foreach (pay[i]) begin
            step(0, 1, pay[i]);
            chk("pay_dout", data_out, 8'hA1 + ((i == 3) ? 8'h11 : 8'h00));
        end
        // Short gap survives, long gap drops sync.
        step(0, 0, 8'h00);
        step(0, 0, 8'h00);
        step(0, 1, 8'h3C);
        chk("gap_sync", {7'd0, sync_active}, 8'd1);
        for (int i = 0; i < LOSS; i++) step(0, 0, 8'h00);
        chk("loss_sync", {7'd0, sync_active}, 8'd0);
        chk("loss_err", err_cnt, 8'd1);
        // Reset mid-ACTIVE.
        for (int i = 0; i < LOCK; i++) step(0, 1, K_COM);
        step(0, 1, 8'h99);
        step(1, 1, 8'h98);
        reset_outputs("rst_active");
        // Reset on the edge that would slip, then during the slip pulse.
        for (int i = 1; i < WIN; i++) step(0, 1, 8'h55);
        step(1, 1, 8'h55);
        reset_outputs("rst_slip_edge");
        for (int i = 1; i <= WIN; i++) step(0, 1, 8'h55);
        step(1, 1, 8'h55);
        reset_outputs("rst_slip_pulse");
        step(0, 1, K_COM);
        // Randomized bursts: comma runs, noisy payload and gaps.
        for (int n = 0; n < 150; n++) begin
            int len;
            int vp;
            len = $urandom_range(2, 30);
            vp = $urandom_range(50, 100);
            if ($urandom_range(0, 2) != 0)
                for (int i = 0; i < $urandom_range(1, 6); i++) step(0, 1, K_COM);
            for (int i = 0; i < len; i++) begin
                int k;
                logic [7:0] b;
                k = $urandom_range(0, 9);
                b = (k < 2) ? K_COM : (k < 3) ? K_IDLE : 8'($urandom);
                step($urandom_range(0, 299) == 0, $urandom_range(1, 100) <= vp, b);
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
